// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
// multicycle_control: multi-cycle CPU controller that sequences a shared ALU and
// a unified memory port across FETCH/DECODE/EXEC/MEM/WB states.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   Op, Fun             - opcode and R-type function fields from the IR
//   equal, sign         - ALU zero flag and result bit 31 (current cycle)
//   MemReady            - memory completed the outstanding request
//   IRWr/PCWr/TgtWr/RegWr, PCSrc, MemRd/MemWr, IorD, RegDst, MemToReg, ExtOp,
//   ALUSrcA, ALUSrcB, ALUctr - datapath control
//   halted              - controller stopped on an illegal encoding
//   retired             - completed-instruction counter (wraps)
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Fun,
    input  logic             equal,
    input  logic             sign,
    input  logic             MemReady,
    output logic             IRWr,
    output logic             PCWr,
    output logic             TgtWr,
    output logic             RegWr,
    output logic             PCSrc,
    output logic             MemRd,
    output logic             MemWr,
    output logic             IorD,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             ExtOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUctr,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned CTR_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_BGTZ  = 6'b000111;

    localparam logic [CTR_W-1:0] CTR_AND  = 3'd0;
    localparam logic [CTR_W-1:0] CTR_OR   = 3'd1;
    localparam logic [CTR_W-1:0] CTR_ADD  = 3'd2;
    localparam logic [CTR_W-1:0] CTR_SLT  = 3'd3;
    localparam logic [CTR_W-1:0] CTR_ADDU = 3'd4;
    localparam logic [CTR_W-1:0] CTR_SLL  = 3'd5;
    localparam logic [CTR_W-1:0] CTR_SUB  = 3'd6;
    localparam logic [CTR_W-1:0] CTR_SLTU = 3'd7;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_R,
        S_WB_I,
        S_WB_MEM,
        S_BRANCH,
        S_HALT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_retire;
    logic               w_r_legal;
    logic [CTR_W-1:0]   w_r_ctr;
    logic               w_taken;
    logic [CNT_W-1:0]   r_retired;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset)         r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end

    assign retired = r_retired;

    // R-type function decode: legality and ALU operation
    always_comb begin
        w_r_legal = 1'b1;
        w_r_ctr   = CTR_AND;
        case (Fun)
            6'b100000: w_r_ctr = CTR_ADD;
            6'b100001: w_r_ctr = CTR_ADDU;
            6'b100010: w_r_ctr = CTR_SUB;
            6'b100011: w_r_ctr = CTR_SUB;
            6'b100100: w_r_ctr = CTR_AND;
            6'b100101: w_r_ctr = CTR_OR;
            6'b000000: w_r_ctr = CTR_SLL;
            6'b101010: w_r_ctr = CTR_SLT;
            6'b101011: w_r_ctr = CTR_SLTU;
            default:   w_r_legal = 1'b0;
        endcase
    end

    // Branch condition from the current-cycle ALU flags
    always_comb begin
        w_taken = 1'b0;
        case (Op)
            OP_BEQ:  w_taken = equal;
            OP_BNE:  w_taken = ~equal;
            OP_BGTZ: w_taken = ~(equal | sign);
            default: w_taken = 1'b0;
        endcase
    end

    // Next-state and control decode
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        TgtWr    = 1'b0;
        RegWr    = 1'b0;
        PCSrc    = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        IorD     = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        ExtOp    = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUctr   = CTR_AND;
        halted   = 1'b0;

        case (r_state)
            S_FETCH: begin
                MemRd   = 1'b1;
                ALUSrcB = 2'b01;
                ALUctr  = CTR_ADDU;
                if (MemReady) begin
                    IRWr   = 1'b1;
                    PCWr   = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUctr  = CTR_ADDU;
                TgtWr   = 1'b1;
                case (Op)
                    OP_RTYPE:               w_next = w_r_legal ? S_EXEC_R : S_HALT;
                    OP_ADDI:                w_next = S_EXEC_I;
                    OP_LW, OP_SW:           w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BGTZ: w_next = S_BRANCH;
                    default:                w_next = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUctr  = w_r_ctr;
                w_next  = S_WB_R;
            end
            S_WB_R: begin
                RegWr    = 1'b1;
                RegDst   = 1'b1;
                ALUctr   = w_r_ctr;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
                ALUctr  = CTR_ADD;
                w_next  = S_WB_I;
            end
            S_WB_I: begin
                RegWr    = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
                ALUctr  = CTR_ADD;
                w_next  = (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                IorD  = 1'b1;
                MemRd = 1'b1;
                if (MemReady) w_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                IorD  = 1'b1;
                MemWr = 1'b1;
                if (MemReady) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_WB_MEM: begin
                RegWr    = 1'b1;
                MemToReg = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUctr   = CTR_SUB;
                PCSrc    = 1'b1;
                PCWr     = w_taken;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset wins over any in-flight request or write
        if (reset) begin
            IRWr     = 1'b0;
            PCWr     = 1'b0;
            TgtWr    = 1'b0;
            RegWr    = 1'b0;
            MemRd    = 1'b0;
            MemWr    = 1'b0;
            w_retire = 1'b0;
        end
    end

endmodule
